// File: rtl/sram_port_arbiter_pkg.sv
// Shared SRAM-port types: funct3 encodings, arbiter state/owner enums, SRAM geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_port_arbiter_pkg;

    localparam int SRAM_READ_LATENCY = 2;
    localparam int SRAM_ADDR_WIDTH   = 11;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } funct3_load_t;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } funct3_store_t;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_RD_WAIT  = 2'd1,
        ARB_RMW_WAIT = 2'd2
    } mem_arb_state_t;

    typedef enum logic {
        OWNER_IMEM = 1'b0,
        OWNER_DMEM = 1'b1
    } mem_owner_t;

    // Access size is encoded as log2(bytes) in funct3[1:0]; size 3 is never legal.
    function automatic logic lane_misaligned(input logic [1:0] size_log2, input logic [1:0] addr_lo);
        logic mis;
        case (size_log2)
            2'd0:    mis = 1'b0;
            2'd1:    mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: load extract/extend, store merge into a read word, misalignment/funct3 check.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module mem_lane_align
    import sram_port_arbiter_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o,
    output logic        rmw_o,
    output logic        err_o
);

    logic [31:0] shifted;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [4:0]  shamt;
    logic        legal_f3;

    assign shamt     = {addr_lo_i, 3'b000};
    assign shifted   = rword_i >> shamt;
    assign lane_data = wdata_i << shamt;

    // Decode funct3, extract/extend loads and merge sub-word stores into the read word.
    always_comb begin
        load_data_o  = '0;
        store_word_o = rword_i;
        lane_mask    = '0;
        rmw_o        = 1'b0;
        legal_f3     = 1'b0;
        if (we_i) begin
            case (funct3_i)
                F3_SB: begin legal_f3 = 1'b1; rmw_o = 1'b1; lane_mask = 32'h0000_00FF << shamt; end
                F3_SH: begin legal_f3 = 1'b1; rmw_o = 1'b1; lane_mask = 32'h0000_FFFF << shamt; end
                F3_SW: begin legal_f3 = 1'b1; lane_mask = 32'hFFFF_FFFF; end
                default: legal_f3 = 1'b0;
            endcase
            store_word_o = (rword_i & ~lane_mask) | (lane_data & lane_mask);
        end else begin
            case (funct3_i)
                F3_LB:  begin legal_f3 = 1'b1; load_data_o = {{24{shifted[7]}},  shifted[7:0]};  end
                F3_LH:  begin legal_f3 = 1'b1; load_data_o = {{16{shifted[15]}}, shifted[15:0]}; end
                F3_LW:  begin legal_f3 = 1'b1; load_data_o = rword_i;                           end
                F3_LBU: begin legal_f3 = 1'b1; load_data_o = {24'h0, shifted[7:0]};             end
                F3_LHU: begin legal_f3 = 1'b1; load_data_o = {16'h0, shifted[15:0]};            end
                default: legal_f3 = 1'b0;
            endcase
        end
    end

    assign err_o = !legal_f3 || lane_misaligned(funct3_i[1:0], addr_lo_i);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one full-word SRAM port between fetch and load/store; sub-word stores via atomic RMW.
// Latency: reads/RMW ack at T+READ_LATENCY, SW and errors ack in the accept cycle T.
// Backpressure: gnt only in IDLE (one access in flight); define SRAM_ARB_RR_EN for round-robin ties.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int READ_LATENCY = SRAM_READ_LATENCY,
    parameter int ADDR_W       = SRAM_ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_req_i,
    input  logic [31:0]       imem_addr_i,
    output logic              imem_gnt_o,
    output logic              imem_rvalid_o,
    output logic [31:0]       imem_rdata_o,
    input  logic              dmem_req_i,
    input  logic              dmem_we_i,
    input  logic [2:0]        dmem_funct3_i,
    input  logic [31:0]       dmem_addr_i,
    input  logic [31:0]       dmem_wdata_i,
    output logic              dmem_gnt_o,
    output logic              dmem_ack_o,
    output logic              dmem_err_o,
    output logic [31:0]       dmem_rdata_o,
    output logic              sram_en_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i
);

    localparam int CNT_W = $clog2(READ_LATENCY + 1);
    localparam logic [1:0] ST_IDLE     = ARB_IDLE;
    localparam logic [1:0] ST_RD_WAIT  = ARB_RD_WAIT;
    localparam logic [1:0] ST_RMW_WAIT = ARB_RMW_WAIT;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mem_owner_t        owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        lo_q, lo_d;
    logic [31:0]       wdata_q, wdata_d;

    logic        idle;
    logic        done;
    logic        dmem_wins;
    logic        dmem_gnt;
    logic        imem_gnt;
    logic        la_we;
    logic [2:0]  la_funct3;
    logic [1:0]  la_lo;
    logic [31:0] la_wdata;
    logic [31:0] la_load;
    logic [31:0] la_store;
    logic        la_rmw;
    logic        la_err;
    logic        unused_addr_bits;

    // Outputs are forced low while rst is high, so grants are also masked by reset.
    assign idle = (state_q == ST_IDLE) && !rst;
    assign done = (state_q != ST_IDLE) && (cnt_q == CNT_W'(READ_LATENCY - 1));

`ifdef SRAM_ARB_RR_EN
    mem_owner_t last_q, last_d;

    assign dmem_wins = (last_q == OWNER_IMEM);

    // Remember who won the most recent grant so the other side wins the next tie.
    always_comb begin
        last_d = last_q;
        if (dmem_gnt)      last_d = OWNER_DMEM;
        else if (imem_gnt) last_d = OWNER_IMEM;
    end

    // Last-owner register; imem after reset so dmem wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= OWNER_IMEM;
        else     last_q <= last_d;
    end
`else
    assign dmem_wins = 1'b1;
`endif

    assign dmem_gnt   = idle && dmem_req_i && (dmem_wins || !imem_req_i);
    assign imem_gnt   = idle && imem_req_i && !dmem_gnt;
    assign imem_gnt_o = imem_gnt;
    assign dmem_gnt_o = dmem_gnt;

    // In IDLE the aligner checks the live request; while waiting it works on the captured access.
    assign la_we     = idle ? dmem_we_i          : (state_q == ST_RMW_WAIT);
    assign la_funct3 = idle ? dmem_funct3_i      : funct3_q;
    assign la_lo     = idle ? dmem_addr_i[1:0]   : lo_q;
    assign la_wdata  = idle ? dmem_wdata_i       : wdata_q;

    mem_lane_align u_align (
        .we_i         (la_we),
        .funct3_i     (la_funct3),
        .addr_lo_i    (la_lo),
        .wdata_i      (la_wdata),
        .rword_i      (sram_rdata_i),
        .load_data_o  (la_load),
        .store_word_o (la_store),
        .rmw_o        (la_rmw),
        .err_o        (la_err)
    );

    // Word-address bits above the SRAM and the fetch byte offset are aliased/ignored.
    assign unused_addr_bits = ^{imem_addr_i[31:ADDR_W+2], imem_addr_i[1:0], dmem_addr_i[31:ADDR_W+2]};

    // Grant handling, SRAM drive, completion pulses and next-state selection.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        funct3_d      = funct3_q;
        lo_d          = lo_q;
        wdata_d       = wdata_q;
        imem_rvalid_o = 1'b0;
        imem_rdata_o  = '0;
        dmem_ack_o    = 1'b0;
        dmem_err_o    = 1'b0;
        dmem_rdata_o  = '0;
        sram_en_o     = 1'b0;
        sram_we_o     = 1'b0;
        sram_addr_o   = '0;
        sram_wdata_o  = '0;
        case (state_q)
            ST_IDLE: begin
                if (dmem_gnt) begin
                    addr_d   = dmem_addr_i[ADDR_W+1:2];
                    funct3_d = dmem_funct3_i;
                    lo_d     = dmem_addr_i[1:0];
                    wdata_d  = dmem_wdata_i;
                    owner_d  = OWNER_DMEM;
                    if (la_err) begin
                        // Rejected without touching the SRAM.
                        dmem_ack_o = 1'b1;
                        dmem_err_o = 1'b1;
                    end else if (dmem_we_i && !la_rmw) begin
                        // Full-word store completes in the accept cycle.
                        sram_en_o    = 1'b1;
                        sram_we_o    = 1'b1;
                        sram_addr_o  = dmem_addr_i[ADDR_W+1:2];
                        sram_wdata_o = la_store;
                        dmem_ack_o   = 1'b1;
                    end else begin
                        sram_en_o   = 1'b1;
                        sram_addr_o = dmem_addr_i[ADDR_W+1:2];
                        cnt_d       = '0;
                        state_d     = la_rmw ? ST_RMW_WAIT : ST_RD_WAIT;
                    end
                end else if (imem_gnt) begin
                    addr_d      = imem_addr_i[ADDR_W+1:2];
                    owner_d     = OWNER_IMEM;
                    sram_en_o   = 1'b1;
                    sram_addr_o = imem_addr_i[ADDR_W+1:2];
                    cnt_d       = '0;
                    state_d     = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (done) begin
                    if (owner_q == OWNER_IMEM) begin
                        imem_rvalid_o = 1'b1;
                        imem_rdata_o  = sram_rdata_i;
                    end else begin
                        dmem_ack_o   = 1'b1;
                        dmem_rdata_o = la_load;
                    end
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RMW_WAIT: begin
                if (done) begin
                    // Write back the merged word; nobody was granted since the read.
                    sram_en_o    = 1'b1;
                    sram_we_o    = 1'b1;
                    sram_addr_o  = addr_q;
                    sram_wdata_o = la_store;
                    dmem_ack_o   = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latency counter and the captured access; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            owner_q  <= OWNER_IMEM;
            addr_q   <= '0;
            funct3_q <= '0;
            lo_q     <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            lo_q     <= lo_d;
            wdata_q  <= wdata_d;
        end
    end

endmodule
